float_classify_clz: RTL and testbench

- Registered classifier for a small custom-width float (sign / exponent / fraction).
- Flags the input as Inf, NaN, zero, denormal or normal, and counts the leading zeros of the fraction field.
- Sits in front of float width-expansion logic, which uses the flags to select special-value handling and the zero count to renormalize denormals.
- One pipeline stage with a valid qualifier.

---
 rtl/float_classify_clz_if.sv | 44 ++++
 rtl/float_classify_clz.sv | 89 ++++++++
 tb/tb_float_classify_clz.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/float_classify_clz_if.sv
// float_classify_clz_if
//   Bundles the input word and the registered classification result of
//   float_classify_clz.
//
//   Handshake: valid-only, no ready. A word is transferred on every rising
//   clock edge where in_valid=1; the consumer can never stall the producer.
//   out_valid is high for exactly the cycle after each accepted word. While
//   out_valid=0 the other outputs keep the last loaded word.
//
//   Modports:
//     master - word producer / result consumer (drives in_*, reads results)
//     slave  - the classifier (reads in_*, drives results)
interface float_classify_clz_if #(
   parameter int EXP  = 3,
   parameter int FRAC = 4
);
   logic                        in_valid;
   logic                        in_sign;
   logic [EXP-1:0]              in_exponent;
   logic [FRAC-1:0]             in_fraction;

   logic                        out_valid;
   logic                        out_sign;
   logic [EXP-1:0]              out_exponent;
   logic [FRAC-1:0]             out_fraction;
   logic                        is_inf;
   logic                        is_nan;
   logic                        is_zero;
   logic                        is_denormal;
   logic                        is_normal;
   logic [$clog2(FRAC+1)-1:0]   clz;

   modport master (
      output in_valid, in_sign, in_exponent, in_fraction,
      input  out_valid, out_sign, out_exponent, out_fraction,
      input  is_inf, is_nan, is_zero, is_denormal, is_normal, clz
   );

   modport slave (
      input  in_valid, in_sign, in_exponent, in_fraction,
      output out_valid, out_sign, out_exponent, out_fraction,
      output is_inf, is_nan, is_zero, is_denormal, is_normal, clz
   );
endinterface

// File: rtl/float_classify_clz.sv
// float_classify_clz
//   One-stage registered classifier for a small sign/exponent/fraction float.
//   Flags the word as Inf, NaN, zero, denormal or normal and counts leading
//   zeros of the fraction so downstream width-expansion logic can pick
//   special-value handling and renormalize denormals.
//
//   Ports:
//     clock - rising-edge clock
//     reset - asynchronous, active-high; clears every output register
//     bus   - float_classify_clz_if slave: in_valid/in_sign/in_exponent/
//             in_fraction in; out_valid, registered copies of the input
//             fields, the five class flags and clz out
module float_classify_clz #(
   parameter int EXP  = 3,
   parameter int FRAC = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   float_classify_clz_if.slave  bus
);
   localparam int CW = $clog2(FRAC + 1);

   if (EXP < 2 || FRAC < 1) begin : g_param_check
      $error("float_classify_clz: EXP must be >= 2 and FRAC must be >= 1");
   end

   logic          exp_ones;
   logic          exp_zero;
   logic          frac_zero;
   logic          inf_c;
   logic          nan_c;
   logic          zero_c;
   logic          denormal_c;
   logic          normal_c;
   logic [CW-1:0] clz_c;

   assign exp_ones   = &bus.in_exponent;
   assign exp_zero   = ~|bus.in_exponent;
   assign frac_zero  = ~|bus.in_fraction;

   // The sign is deliberately not used: -0 is a zero, -Inf is an Inf.
   assign inf_c      = exp_ones & frac_zero;
   assign nan_c      = exp_ones & ~frac_zero;
   assign zero_c     = exp_zero & frac_zero;
   assign denormal_c = exp_zero & ~frac_zero;
   assign normal_c   = ~exp_ones & ~exp_zero;

   // Priority encoder: scanning upward, each set bit overrides the result,
   // so the most significant set bit decides. No set bit leaves FRAC.
   // Synthesis flattens this into a log-depth encoder, fine up to FRAC=52.
   always_comb begin
      clz_c = CW'(FRAC);
      for (int i = 0; i < FRAC; i++) begin
         if (bus.in_fraction[i]) begin
            clz_c = CW'(FRAC - 1 - i);
         end
      end
   end

   // out_valid tracks in_valid every cycle; everything else only loads on a
   // valid word so consumers can keep reading the last result while idle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.out_valid    <= 1'b0;
         bus.out_sign     <= 1'b0;
         bus.out_exponent <= '0;
         bus.out_fraction <= '0;
         bus.is_inf       <= 1'b0;
         bus.is_nan       <= 1'b0;
         bus.is_zero      <= 1'b0;
         bus.is_denormal  <= 1'b0;
         bus.is_normal    <= 1'b0;
         bus.clz          <= '0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.out_sign     <= bus.in_sign;
            bus.out_exponent <= bus.in_exponent;
            bus.out_fraction <= bus.in_fraction;
            bus.is_inf       <= inf_c;
            bus.is_nan       <= nan_c;
            bus.is_zero      <= zero_c;
            bus.is_denormal  <= denormal_c;
            bus.is_normal    <= normal_c;
            bus.clz          <= clz_c;
         end
      end
   end
endmodule

// File: tb/tb_float_classify_clz.sv
// tb_float_classify_clz
//   Drives a FRAC=4 and a FRAC=1 instance of float_classify_clz (EXP=3).
//   Expected words are queued when driven and compared when out_valid rises.
//   Packed result layout: {sign, exponent, fraction, inf, nan, zero, den,
//   normal, clz}.
module tb_float_classify_clz;
   logic clock;
   logic reset;

   float_classify_clz_if #(.EXP(3), .FRAC(4)) bus4 ();
   float_classify_clz_if #(.EXP(3), .FRAC(1)) bus1 ();

   float_classify_clz #(.EXP(3), .FRAC(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   float_classify_clz #(.EXP(3), .FRAC(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int pops4    = 0;
   logic [15:0] exp4_q[$];
   logic [10:0] exp1_q[$];

   localparam logic [4:0] F_INF  = 5'b10000;
   localparam logic [4:0] F_NAN  = 5'b01000;
   localparam logic [4:0] F_ZERO = 5'b00100;
   localparam logic [4:0] F_DEN  = 5'b00010;
   localparam logic [4:0] F_NORM = 5'b00001;

   typedef struct {
      logic       s;
      logic [2:0] e;
      logic [3:0] f;
      logic [4:0] fl;
      logic [2:0] z;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   function automatic logic [15:0] act4();
      return {bus4.out_sign, bus4.out_exponent, bus4.out_fraction,
              bus4.is_inf, bus4.is_nan, bus4.is_zero, bus4.is_denormal,
              bus4.is_normal, bus4.clz};
   endfunction

   function automatic logic [10:0] act1();
      return {bus1.out_sign, bus1.out_exponent, bus1.out_fraction,
              bus1.is_inf, bus1.is_nan, bus1.is_zero, bus1.is_denormal,
              bus1.is_normal, bus1.clz};
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [4:0] class_of(input logic [2:0] e, input logic fz);
      if (e == 3'd7) return fz ? F_INF : F_NAN;
      if (e == 3'd0) return fz ? F_ZERO : F_DEN;
      return F_NORM;
   endfunction

   function automatic logic [15:0] model4(input logic s, input logic [2:0] e, input logic [3:0] f);
      logic [2:0] z;
      logic       seen;
      z    = 3'd0;
      seen = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (f[i]) seen = 1'b1;
         if (!seen) z = z + 3'd1;
      end
      return {s, e, f, class_of(e, f == 4'd0), z};
   endfunction

   function automatic logic [10:0] model1(input logic s, input logic [2:0] e, input logic f);
      return {s, e, f, class_of(e, !f), !f};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive4(input logic v, input logic s, input logic [2:0] e,
                         input logic [3:0] f, input logic [15:0] exp_word);
      @(negedge clock);
      bus4.in_valid    = v;
      bus4.in_sign     = s;
      bus4.in_exponent = e;
      bus4.in_fraction = f;
      if (v) exp4_q.push_back(exp_word);
   endtask

   task automatic drive1(input logic v, input logic s, input logic [2:0] e,
                         input logic f, input logic [10:0] exp_word);
      @(negedge clock);
      bus1.in_valid    = v;
      bus1.in_sign     = s;
      bus1.in_exponent = e;
      bus1.in_fraction = f;
      if (v) exp1_q.push_back(exp_word);
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clock) begin
      if (!reset && bus4.out_valid) begin
         check("sb4_pending", 32'(exp4_q.size() != 0), 32'd1);
         if (exp4_q.size() != 0) begin
            check("out4_word", 32'(act4()), 32'(exp4_q.pop_front()));
            check("onehot4", 32'($countones({bus4.is_inf, bus4.is_nan, bus4.is_zero,
                                             bus4.is_denormal, bus4.is_normal})), 32'd1);
            pops4++;
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && bus1.out_valid) begin
         check("sb1_pending", 32'(exp1_q.size() != 0), 32'd1);
         if (exp1_q.size() != 0) begin
            check("out1_word", 32'(act1()), 32'(exp1_q.pop_front()));
            check("onehot1", 32'($countones({bus1.is_inf, bus1.is_nan, bus1.is_zero,
                                             bus1.is_denormal, bus1.is_normal})), 32'd1);
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [7:0] w8;
      logic [4:0] w5;
      int         p0;

      tbl[0] = '{1'b1, 3'b111, 4'b0000, F_INF,  3'd4};
      tbl[1] = '{1'b0, 3'b111, 4'b0100, F_NAN,  3'd1};
      tbl[2] = '{1'b1, 3'b000, 4'b0000, F_ZERO, 3'd4};
      tbl[3] = '{1'b0, 3'b000, 4'b0011, F_DEN,  3'd2};
      tbl[4] = '{1'b0, 3'b000, 4'b0001, F_DEN,  3'd3};
      tbl[5] = '{1'b0, 3'b010, 4'b1000, F_NORM, 3'd0};
      tbl[6] = '{1'b0, 3'b110, 4'b0000, F_NORM, 3'd4};
      tbl[7] = '{1'b0, 3'b111, 4'b0001, F_NAN,  3'd3};
      tbl[8] = '{1'b1, 3'b001, 4'b1111, F_NORM, 3'd0};
      tbl[9] = '{1'b0, 3'b000, 4'b1000, F_DEN,  3'd0};

      reset = 1'b1;
      bus4.in_valid = 1'b0; bus4.in_sign = 1'b0; bus4.in_exponent = '0; bus4.in_fraction = '0;
      bus1.in_valid = 1'b0; bus1.in_sign = 1'b0; bus1.in_exponent = '0; bus1.in_fraction = '0;

      #1;
      check("reset_init4", 32'({bus4.out_valid, act4()}), 32'd0);
      check("reset_init1", 32'({bus1.out_valid, act1()}), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // 1. reset asserted mid-stream, in-flight word discarded
      drive4(1'b1, 1'b0, 3'b010, 4'b0110, {1'b0, 3'b010, 4'b0110, F_NORM, 3'd1});
      drive4(1'b1, 1'b1, 3'b111, 4'b0000, {1'b1, 3'b111, 4'b0000, F_INF, 3'd4});
      #2;
      reset = 1'b1;
      exp4_q.delete();
      #1;
      check("reset_async4", 32'({bus4.out_valid, act4()}), 32'd0);
      check("reset_async1", 32'({bus1.out_valid, act1()}), 32'd0);
      bus4.in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("idle_out_valid", 32'(bus4.out_valid), 32'd0);
      end

      // 2-4. special values, zeros, denormals, normals from the table
      for (int i = 0; i < 10; i++) begin
         drive4(1'b1, tbl[i].s, tbl[i].e, tbl[i].f,
                {tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].fl, tbl[i].z});
      end
      drive4(1'b0, 1'b0, 3'b000, 4'b0000, 16'd0);
      @(negedge clock);

      // 5. back-to-back stream, then hold with garbage on the idle inputs
      p0 = pops4;
      drive4(1'b1, 1'b0, 3'b111, 4'b0000, {1'b0, 3'b111, 4'b0000, F_INF,  3'd4});
      drive4(1'b1, 1'b0, 3'b000, 4'b0011, {1'b0, 3'b000, 4'b0011, F_DEN,  3'd2});
      drive4(1'b1, 1'b0, 3'b101, 4'b1010, {1'b0, 3'b101, 4'b1010, F_NORM, 3'd0});
      drive4(1'b0, 1'b1, 3'b111, 4'b0000, 16'd0);
      @(negedge clock);
      check("stream_len", 32'(pops4 - p0), 32'd3);
      check("hold_valid", 32'(bus4.out_valid), 32'd0);
      check("hold_word", 32'(act4()), 32'({1'b0, 3'b101, 4'b1010, F_NORM, 3'd0}));
      @(negedge clock);
      check("hold_word_2", 32'(act4()), 32'({1'b0, 3'b101, 4'b1010, F_NORM, 3'd0}));

      // 6a. exhaustive sweep, FRAC=4, with random idle gaps
      for (int i = 0; i < 256; i++) begin
         w8 = 8'(i);
         if ($urandom_range(0, 3) == 0)
            drive4(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)), 16'd0);
         drive4(1'b1, w8[7], w8[6:4], w8[3:0], model4(w8[7], w8[6:4], w8[3:0]));
      end
      drive4(1'b0, 1'b0, 3'b000, 4'b0000, 16'd0);

      // 6b. FRAC=1: hand vectors, then exhaustive sweep
      drive1(1'b1, 1'b0, 3'b011, 1'b0, {1'b0, 3'b011, 1'b0, F_NORM, 1'b1});
      drive1(1'b1, 1'b0, 3'b011, 1'b1, {1'b0, 3'b011, 1'b1, F_NORM, 1'b0});
      drive1(1'b1, 1'b1, 3'b000, 1'b1, {1'b1, 3'b000, 1'b1, F_DEN,  1'b0});
      drive1(1'b1, 1'b0, 3'b111, 1'b0, {1'b0, 3'b111, 1'b0, F_INF,  1'b1});
      for (int i = 0; i < 32; i++) begin
         w5 = 5'(i);
         if ($urandom_range(0, 3) == 0)
            drive1(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 11'd0);
         drive1(1'b1, w5[4], w5[3:1], w5[0], model1(w5[4], w5[3:1], w5[0]));
      end
      drive1(1'b0, 1'b0, 3'b000, 1'b0, 11'd0);

      // drain and confirm nothing was left unmatched
      repeat (3) @(negedge clock);
      check("drain4", 32'(exp4_q.size()), 32'd0);
      check("drain1", 32'(exp1_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
